mutative_dfp_arbiter: RTL
=========================

Name: mutative_dfp_arbiter

Overview:
Shares the single DFP (memory-side port) of the mutative cache between two requesters: the miss path (line fills and evictions) and the flush engine (dirty-line writebacks during a setup change). It allows one outstanding DFP transaction at a time and applies flush priority while reconfiguration is in progress. A per-requester wait counter prevents starvation, and a watchdog flags a DFP that never responds. It sits between the cache datapath/flush engine and the DFP interface.

Parameters:
ADDR_WIDTH, 32, DFP address width
LINE_WIDTH, 256, cacheline data width
MAX_WAIT, 4, consecutive lost arbitrations before a requester is forced to win
TIMEOUT, 1024, cycles in BUSY without dfp_resp before timeout_err sets

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
flush_pri  input  1  flush requester favoured, high while a setup change is in progress
miss_valid  input  1  miss path request; held with its fields stable until miss_resp
miss_write  input  1  1 = write, 0 = read
miss_addr  input  ADDR_WIDTH  line-aligned address
miss_wdata  input  LINE_WIDTH  write data
miss_resp  output  1  one-cycle completion pulse to miss path
flush_valid  input  1  flush request; held with its fields stable until flush_resp
flush_write  input  1  1 = write, 0 = read
flush_addr  input  ADDR_WIDTH  line-aligned address
flush_wdata  input  LINE_WIDTH  write data
flush_resp  output  1  one-cycle completion pulse to flush engine
rdata  output  LINE_WIDTH  dfp_rdata passthrough, valid only with a resp pulse
dfp_addr  output  ADDR_WIDTH  latched command address
dfp_read  output  1  read command, held until dfp_resp
dfp_write  output  1  write command, held until dfp_resp
dfp_wdata  output  LINE_WIDTH  latched write data
dfp_rdata  input  LINE_WIDTH  read data
dfp_resp  input  1  transaction complete
busy  output  1  a transaction is outstanding
owner  output  1  current or last grant: 0 = miss, 1 = flush
timeout_err  output  1  sticky watchdog error

Behaviour:
- Reset values: every output is 0, and so are the state, wait counters and watchdog count. When rst asserts mid-transaction, the command is dropped and the block returns to IDLE.
- States:
  - IDLE: arbitrate among the valid requesters. On a grant, latch addr, wdata, write and owner, then move to BUSY. With no valid requester, stay in IDLE.
  - BUSY: drive exactly one of dfp_read or dfp_write from the latched command, and keep it stable. When dfp_resp arrives, pulse the owner's resp in the same cycle, pass rdata through combinationally, deassert the command on the next edge and return to IDLE.
- Latency:
  - A request valid in IDLE at cycle N produces a DFP command at N+1.
  - The minimum gap between back-to-back transactions is one IDLE cycle.
  - Responses are combinational from dfp_resp.
- Arbitration when both requesters are valid in IDLE:
  - A requester whose wait count equals MAX_WAIT wins.
  - If both counts are saturated, miss wins.
  - Otherwise flush wins if flush_pri = 1, and miss wins if flush_pri = 0.
  - A single valid requester always wins.
- Wait counters:
  - Width is clog2(MAX_WAIT+1).
  - A counter increments in an IDLE cycle where its requester is valid but not granted, and saturates at MAX_WAIT.
  - It clears on grant.
  - It holds otherwise, including during BUSY.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without dfp_resp.
  - At TIMEOUT, timeout_err sets; it clears only on reset. The transaction keeps waiting and is not aborted.
- dfp_resp seen in IDLE is ignored: no resp pulse, no state change.
- A requester dropping valid during BUSY is a protocol violation. The transaction still completes and the resp pulse is still issued.
- flush_pri changing during BUSY affects only the next arbitration.
- busy = (state == BUSY). owner holds its value after completion.

Decomposition:
- mutative_types gains:
  - arb_state_t enum {arb_idle, arb_busy}
  - requester id enum {req_miss = 0, req_flush = 1}
- Sub-module mutative_wait_counter: saturating counter with inc, clr and sat output, parameterised by MAX_WAIT. It is instantiated once per requester.

Test Plan:
- Miss read alone: miss_valid=1, addr=0x1000, write=0 at cycle 0 → dfp_read=1 and dfp_addr=0x1000 at cycle 1; dfp_resp at cycle 4 with rdata=0xA5…A5 → miss_resp pulses at cycle 4 with rdata=0xA5…A5; busy=0 at cycle 5.
- Contention under flush_pri=1: both valid, flush write 0x2000 → flush granted first; miss_wait=1; miss granted in the IDLE cycle after flush_resp.
- Starvation: flush_pri=1, flush_valid re-raised immediately after each response, miss_valid held, MAX_WAIT=4 → after 4 flush grants the miss wins the 5th arbitration even though flush_pri=1.
- Timeout: grant a read and withhold dfp_resp for 1024 cycles → timeout_err=1 at cycle 1024 of BUSY and stays high; a late dfp_resp still pulses the owner's resp.
- Reset mid-BUSY: assert rst low during a write → dfp_write, busy and resp go to 0 immediately (asynchronously); a dfp_resp arriving after reset release causes no resp pulse.
- Stray response: dfp_resp=1 in IDLE with no requests → no resp pulses, state stays IDLE.

Source files
------------

// File: rtl/mutative_types.sv
// Shared types for the mutative cache DFP arbiter: FSM states, requester ids
// and the arbitration decision.
package mutative_types;

   typedef enum logic {
      arb_idle = 1'b0,
      arb_busy = 1'b1
   } arb_state_t;

   typedef enum logic {
      req_miss  = 1'b0,
      req_flush = 1'b1
   } req_id_t;

   // Starvation guard outranks flush_pri; a double saturation falls back to miss.
   function automatic req_id_t arb_pick(input logic miss_v,
                                        input logic flush_v,
                                        input logic miss_sat,
                                        input logic flush_sat,
                                        input logic flush_pri);
      if (miss_v && !flush_v) return req_miss;
      if (flush_v && !miss_v) return req_flush;
      if (miss_sat) return req_miss;
      if (flush_sat) return req_flush;
      return flush_pri ? req_flush : req_miss;
   endfunction

endpackage

// File: rtl/mutative_wait_counter.sv
// Saturating count of consecutive lost arbitrations for one requester.
// Latency: sat reflects the registered count. No backpressure; clr beats inc.
module mutative_wait_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/mutative_dfp_arbiter.sv
// Shares the cache DFP between the miss path and the flush engine, one transaction at a time.
// Latency: request in IDLE -> DFP command next cycle; resp pulses are combinational from dfp_resp.
// Backpressure: requesters hold valid until their resp; losers wait, starvation-capped at MAX_WAIT.
module mutative_dfp_arbiter
   import mutative_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int MAX_WAIT   = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_pri,
   input  logic                  miss_valid,
   input  logic                  miss_write,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   input  logic [LINE_WIDTH-1:0] miss_wdata,
   output logic                  miss_resp,
   input  logic                  flush_valid,
   input  logic                  flush_write,
   input  logic [ADDR_WIDTH-1:0] flush_addr,
   input  logic [LINE_WIDTH-1:0] flush_wdata,
   output logic                  flush_resp,
   output logic [LINE_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] dfp_addr,
   output logic                  dfp_read,
   output logic                  dfp_write,
   output logic [LINE_WIDTH-1:0] dfp_wdata,
   input  logic [LINE_WIDTH-1:0] dfp_rdata,
   input  logic                  dfp_resp,
   output logic                  busy,
   output logic                  owner,
   output logic                  timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   arb_state_t      state;
   req_id_t         owner_id;
   req_id_t         grant_id;
   logic [WD_W-1:0] wd_cnt;
   logic            grant;
   logic            miss_win;
   logic            flush_win;
   logic            miss_sat;
   logic            flush_sat;
   logic            resp_fire;

   assign grant     = (state == arb_idle) && (miss_valid || flush_valid);
   assign grant_id  = arb_pick(miss_valid, flush_valid, miss_sat, flush_sat, flush_pri);
   assign miss_win  = grant && (grant_id == req_miss);
   assign flush_win = grant && (grant_id == req_flush);

   mutative_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_miss_wait (
      .clk (clk),
      .rst (rst),
      .inc ((state == arb_idle) && miss_valid && !miss_win),
      .clr (miss_win),
      .sat (miss_sat)
   );

   mutative_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_flush_wait (
      .clk (clk),
      .rst (rst),
      .inc ((state == arb_idle) && flush_valid && !flush_win),
      .clr (flush_win),
      .sat (flush_sat)
   );

   // A response outside BUSY is a stray and must not reach either requester.
   assign resp_fire  = (state == arb_busy) && dfp_resp;
   assign miss_resp  = resp_fire && (owner_id == req_miss);
   assign flush_resp = resp_fire && (owner_id == req_flush);
   assign rdata      = resp_fire ? dfp_rdata : '0;
   assign busy       = (state == arb_busy);
   assign owner      = owner_id;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= arb_idle;
         owner_id    <= req_miss;
         dfp_addr    <= '0;
         dfp_wdata   <= '0;
         dfp_read    <= 1'b0;
         dfp_write   <= 1'b0;
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            arb_idle: begin
               if (grant) begin
                  state    <= arb_busy;
                  owner_id <= grant_id;
                  wd_cnt   <= '0;
                  if (grant_id == req_flush) begin
                     dfp_addr  <= flush_addr;
                     dfp_wdata <= flush_wdata;
                     dfp_write <= flush_write;
                     dfp_read  <= !flush_write;
                  end else begin
                     dfp_addr  <= miss_addr;
                     dfp_wdata <= miss_wdata;
                     dfp_write <= miss_write;
                     dfp_read  <= !miss_write;
                  end
               end
            end
            arb_busy: begin
               if (dfp_resp) begin
                  state     <= arb_idle;
                  dfp_read  <= 1'b0;
                  dfp_write <= 1'b0;
               end else begin
                  // The watchdog only reports; the transaction keeps waiting.
                  if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                  if (wd_cnt == WD_LAST) timeout_err <= 1'b1;
               end
            end
            default: state <= arb_idle;
         endcase
      end
   end

endmodule
